// File: rtl/gate_vector_tester_if.sv
// gate_vector_tester_if: stimulus, result and control signals between the tester and its user/gate under test.
interface gate_vector_tester_if;
  logic start;
  logic dut_o;
  logic a, b, c, d;
  logic busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_fail;
  modport master (input start, dut_o, output a, b, c, d, busy, done, pass, err_count, first_fail);
  modport slave (output start, dut_o, input a, b, c, d, busy, done, pass, err_count, first_fail);
endinterface

// File: rtl/gate_vector_tester.sv
// gate_vector_tester: exhaustive 16-vector checker for an OAI22 gate with a programmable settle time per vector.
module gate_vector_tester #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  gate_vector_tester_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [3:0] SC = 4'(SETTLE_CYCLES);
  // with no settle time each vector goes straight to sampling
  localparam state_t RUN = (SC == 4'd0) ? SAMPLE : SETTLE;
  state_t state, next;
  logic [3:0] idx, cnt, first_fail;
  logic [4:0] err_count;
  logic failed, exp_o, go;
  assign go = (state == IDLE || state == DONE) && bus.start;
  assign exp_o = ~((idx[3] & idx[2]) | (idx[1] & idx[0]));
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = bus.start ? RUN : state;
      SETTLE:     next = (cnt == 4'd1) ? SAMPLE : SETTLE;
      SAMPLE:     next = (idx == 4'd15) ? DONE : RUN;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= 4'd0;
      cnt <= 4'd0;
      err_count <= 5'd0;
      first_fail <= 4'd0;
      failed <= 1'b0;
    end else begin
      state <= next;
      if (go) begin
        idx <= 4'd0;
        cnt <= SC;
        err_count <= 5'd0;
        first_fail <= 4'd0;
        failed <= 1'b0;
      end else if (state == SETTLE) begin
        cnt <= cnt - 4'd1;
      end else if (state == SAMPLE) begin
        if (bus.dut_o != exp_o) begin
          err_count <= err_count + 5'd1;
          if (!failed) first_fail <= idx;
          failed <= 1'b1;
        end
        if (idx != 4'd15) idx <= idx + 4'd1;
        cnt <= SC;
      end
    end
  end
  assign {bus.a, bus.b, bus.c, bus.d} = idx;
  assign bus.busy = (state == SETTLE) || (state == SAMPLE);
  assign bus.done = state == DONE;
  assign bus.pass = (state == DONE) && (err_count == 5'd0);
  assign bus.err_count = err_count;
  assign bus.first_fail = first_fail;
endmodule

// File: tb/tb_gate_vector_tester.sv
// tb_gate_vector_tester: runs two testers (settle 2 and settle 0) in lockstep against a modelled OAI22 with injectable faults.
module tb_gate_vector_tester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int mode = 0;
  logic [15:0] mask = 16'h0;
  int total = 0;
  int bad = 0;

  gate_vector_tester_if if2 ();
  gate_vector_tester_if if0 ();

  gate_vector_tester #(.SETTLE_CYCLES(2)) u2 (.clk(clk), .rst(rst), .bus(if2.master));
  gate_vector_tester #(.SETTLE_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(if0.master));

  always #5 clk = ~clk;

  function automatic logic gate(input logic [3:0] v);
    logic ideal;
    ideal = ~((v[3] & v[2]) | (v[1] & v[0]));
    return (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (ideal ^ mask[v]);
  endfunction

  assign if2.start = start;
  assign if0.start = start;
  assign if2.dut_o = gate({if2.a, if2.b, if2.c, if2.d});
  assign if0.dut_o = gate({if0.a, if0.b, if0.c, if0.d});

  typedef struct {
    int mode;
    logic [15:0] mask;
    logic [4:0] err;
    logic [3:0] ff;
    logic pass;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " abcd2"}, {if2.a, if2.b, if2.c, if2.d}, 0);
    chk({tag, " busy2"}, if2.busy, 0);
    chk({tag, " done2"}, if2.done, 0);
    chk({tag, " pass2"}, if2.pass, 0);
    chk({tag, " err2"}, if2.err_count, 0);
    chk({tag, " ff2"}, if2.first_fail, 0);
    chk({tag, " abcd0"}, {if0.a, if0.b, if0.c, if0.d}, 0);
    chk({tag, " busy0"}, if0.busy, 0);
    chk({tag, " done0"}, if0.done, 0);
    chk({tag, " err0"}, if0.err_count, 0);
  endtask

  task automatic run(input string nm, input vec_t v, input logic glitch);
    int t2, t0;
    mode = v.mode;
    mask = v.mask;
    t2 = -1;
    t0 = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({nm, " busy2@start"}, if2.busy, 1);
    chk({nm, " busy0@start"}, if0.busy, 1);
    for (int k = 1; k <= 200 && (t2 < 0 || t0 < 0); k++) begin
      if (glitch && k == 10) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (t2 < 0 && if2.done) t2 = k;
      if (t0 < 0 && if0.done) t0 = k;
      if (k < 48) chk({nm, " step2"}, {if2.a, if2.b, if2.c, if2.d}, k / 3);
      if (k < 16) chk({nm, " step0"}, {if0.a, if0.b, if0.c, if0.d}, k);
    end
    chk({nm, " cycles2"}, t2, 48);
    chk({nm, " cycles0"}, t0, 16);
    chk({nm, " err2"}, if2.err_count, v.err);
    chk({nm, " ff2"}, if2.first_fail, v.ff);
    chk({nm, " pass2"}, if2.pass, v.pass);
    chk({nm, " busy2"}, if2.busy, 0);
    chk({nm, " err0"}, if0.err_count, v.err);
    chk({nm, " ff0"}, if0.first_fail, v.ff);
    chk({nm, " pass0"}, if0.pass, v.pass);
    chk({nm, " done0"}, if0.done, 1);
    repeat (3) @(negedge clk);
    chk({nm, " hold abcd2"}, {if2.a, if2.b, if2.c, if2.d}, 15);
    chk({nm, " hold err2"}, if2.err_count, v.err);
    chk({nm, " hold done2"}, if2.done, 1);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t r;
    tbl[0] = '{0, 16'h0000, 5'd0, 4'd0, 1'b1};
    tbl[1] = '{1, 16'h0000, 5'd7, 4'd3, 1'b0};
    tbl[2] = '{2, 16'h0000, 5'd9, 4'd0, 1'b0};
    tbl[3] = '{0, 16'h8000, 5'd1, 4'd15, 1'b0};
    tbl[4] = '{0, 16'hFFFF, 5'd16, 4'd0, 1'b0};
    tbl[5] = '{0, 16'h0020, 5'd1, 4'd5, 1'b0};
    #1;
    chk_zero("reset");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("idle");
    for (int i = 0; i < 6; i++) run($sformatf("tbl%0d", i), tbl[i], i == 1);
    // abort at vector 5 while settling, then confirm it stays idle
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre-abort abcd2", {if2.a, if2.b, if2.c, if2.d}, 5);
    #2 rst = 1'b1;
    #1;
    chk_zero("abort");
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_zero("post-abort");
    run("after-abort", tbl[0], 1'b0);
    for (int i = 0; i < 12; i++) begin
      r.mode = 0;
      r.mask = (i % 4 == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      r.err = 5'd0;
      r.ff = 4'd0;
      for (int j = 15; j >= 0; j--)
        if (r.mask[j]) begin
          r.err++;
          r.ff = 4'(j);
        end
      r.pass = r.mask == 16'h0;
      run($sformatf("rnd%0d", i), r, i % 3 == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gate_vector_tester.md
GATE_VECTOR_TESTER -- requirements
Module: gate_vector_tester

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: clock cycles a vector is held before the gate output is sampled (0..15).
REQ-002 The block SHALL have port clk, input, 1 bit: sole clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a full 16-vector exhaustive test.
REQ-005 The block SHALL have port dut_o, input, 1 bit: output of the OAI22 gate under test.
REQ-006 The block SHALL have ports a, b, c, d, outputs, 1 bit each: registered stimulus driven to the gate inputs.
REQ-007 The block SHALL have port busy, output, 1 bit: a test is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: the test has completed and results are valid.
REQ-009 The block SHALL have port pass, output, 1 bit: all 16 samples matched the expected value.
REQ-010 The block SHALL have port err_count, output, 5 bits: number of mismatching vectors, 0..16.
REQ-011 The block SHALL have port first_fail, output, 4 bits: vector index of the first mismatch, or 0 when there is none.

Function
REQ-012 The block SHALL hold a 4-bit vector index idx and drive {a,b,c,d} = idx[3:0], with a as the MSB.
REQ-013 The expected value for each vector SHALL be exp = ~((a & b) | (c & d)), evaluated on the currently driven a, b, c and d.
REQ-014 The state machine SHALL have four states: IDLE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL load idx=0, clear err_count, first_fail and the fail flag, and enter SETTLE with the settle counter set to SETTLE_CYCLES; if SETTLE_CYCLES=0 it SHALL enter SAMPLE directly.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles with idx held constant, then transition to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle; at the ending edge dut_o is compared with exp, and on mismatch err_count increments and, if this is the first mismatch, first_fail is set to idx.
REQ-018 At the end of SAMPLE, if idx<15 the block SHALL increment idx and re-enter SETTLE (or SAMPLE if SETTLE_CYCLES=0); if idx=15 it SHALL enter DONE.
REQ-019 Each vector SHALL occupy SETTLE_CYCLES+1 cycles, so DONE is entered exactly 16*(SETTLE_CYCLES+1) edges after the start edge.
REQ-020 busy SHALL be 1 exactly in SETTLE and SAMPLE, and done SHALL be 1 exactly in DONE.
REQ-021 pass SHALL be 1 only in DONE and only when err_count==0.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 In DONE, the outputs a–d, err_count and first_fail SHALL hold their values until a new start is accepted.
REQ-024 err_count SHALL saturate naturally at 16, which cannot overflow 5 bits.
REQ-025 dut_o SHALL be sampled only in SAMPLE, and its value in any other state SHALL have no effect.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for a clock edge, force: state IDLE, idx=0, a=b=c=d=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
REQ-027 Reset asserted mid-test SHALL abort the test with no partial results retained, and after release the block SHALL remain in IDLE until start is applied.

Verification
REQ-028 With SETTLE_CYCLES=2 and an ideal OAI22 connected, pulsing start SHALL give busy for 48 cycles, then done=1, pass=1, err_count=0, first_fail=0.
REQ-029 With dut_o tied to 1, the block SHALL report done=1, pass=0, err_count=7 (vectors 3,7,11,12,13,14,15) and first_fail=3.
REQ-030 With dut_o tied to 0, the block SHALL report err_count=9 and first_fail=0, with pass=0.
REQ-031 With SETTLE_CYCLES=0 and an ideal gate, done SHALL rise 16 cycles after the start edge, and a–d SHALL step through 0..15 one value per cycle.
REQ-032 Asserting rst at vector 5 mid-SETTLE SHALL clear all outputs to 0 asynchronously, and the block SHALL stay IDLE after release until start.
REQ-033 Pulsing start while busy SHALL leave the cycle count and results unchanged, and pulsing start in DONE SHALL clear the results and rerun the full test.
